// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam int              CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX   = 16'hFFFF;
    localparam int              WAIT_CNT_W = 8;

    // One bundle of pipeline-register controls, so that a whole decision can be
    // assigned at once.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_bubble;
    } ctrl_out_t;

    // Free-running pipeline: everything loads, nothing is squashed.
    localparam ctrl_out_t CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b0
    };

    // Data-memory wait: front of the pipe frozen, WB keeps draining bubbles.
    localparam ctrl_out_t CTRL_MEM_STALL = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b1
    };

    // Timeout: the whole pipe is frozen and nothing may write back.
    localparam ctrl_out_t CTRL_ERROR = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b1
    };

    // Reset: nothing loads and every stage boundary is forced to a NOP.
    localparam ctrl_out_t CTRL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1, memwb_bubble: 1'b1
    };

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use hazard term: the load in EX targets a register that decode reads.
module load_use_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_wbs,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare each source actually read against the load destination.
    always_comb begin
        rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard  = ex_mem_read && ex_wbs && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: load-use stalls,
// branch squashes, data-memory waits with timeout, and performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_wbs,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_bubble,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);

    ctrl_state_t           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]      flush_count_q, flush_count_d;

    logic      load_use;
    logic      mem_stall;
    ctrl_out_t dec_out;
    logic      dec_branch;
    ctrl_out_t ctrl;
    logic      count_flush;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_wbs      (ex_wbs),
        .hazard      (load_use)
    );

    // Normal-decode priority: memory stall, then branch, then load-use.
    always_comb begin
        mem_stall  = mem_req && !mem_ready;
        dec_out    = CTRL_RUN;
        dec_branch = 1'b0;
        if (mem_stall) begin
            dec_out = CTRL_MEM_STALL;
        end else if (branch_taken) begin
            // A branch also squashes any hazarding decode instruction.
            dec_out.ifid_flush = 1'b1;
            dec_out.idex_flush = 1'b1;
            dec_branch         = 1'b1;
        end else if (load_use) begin
            dec_out.pc_en      = 1'b0;
            dec_out.ifid_en    = 1'b0;
            dec_out.idex_flush = 1'b1;
        end
    end

    // Controller FSM: next state, wait counter, timeout flag and output select.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        ctrl          = dec_out;
        count_flush   = 1'b0;
        case (state_q)
            RUN: begin
                count_flush = dec_branch;
                if (mem_stall) begin
                    // wait_cnt counts frozen cycles including the current one,
                    // so the limit is reached on the MEM_WAIT_MAX-th frozen cycle.
                    wait_cnt_d = WAIT_CNT_W'(1);
                    if (WAIT_MAX == WAIT_CNT_W'(1)) begin
                        state_d       = ERROR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Release cycle: any branch held while EX was frozen acts now.
                    count_flush = dec_branch;
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                end else begin
                    ctrl       = CTRL_MEM_STALL;
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                    if (wait_cnt_d == WAIT_MAX) begin
                        state_d       = ERROR;
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            ERROR: begin
                ctrl = CTRL_ERROR;
            end
            default: begin
                ctrl    = CTRL_ERROR;
                state_d = RUN;
            end
        endcase
        if (rst) begin
            ctrl        = CTRL_RESET;
            count_flush = 1'b0;
        end
    end

    // Performance counters, both saturating.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!ctrl.pc_en) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end
        if (count_flush) begin
            flush_count_d = sat_inc(flush_count_q);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Drive ports; status reads as cleared while reset is held.
    always_comb begin
        pc_en        = ctrl.pc_en;
        ifid_en      = ctrl.ifid_en;
        idex_en      = ctrl.idex_en;
        exmem_en     = ctrl.exmem_en;
        memwb_en     = ctrl.memwb_en;
        ifid_flush   = ctrl.ifid_flush;
        idex_flush   = ctrl.idex_flush;
        memwb_bubble = ctrl.memwb_bubble;
        mem_timeout  = mem_timeout_q && !rst;
        stall_cycles = rst ? '0 : stall_cycles_q;
        flush_count  = rst ? '0 : flush_count_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_WAIT_MAX overridden to 4).
module tb_pipeline_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_wbs;
    logic        branch_taken, mem_req, mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [15:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (4),
        .MEM_WAIT_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_wbs       (ex_wbs),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_bubble (memwb_bubble),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_wbs = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // {pc,ifid,idex,exmem,memwb} enables as a 5-bit vector.
    function automatic logic [31:0] ens();
        return {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        settle();
        chk("rst_enables", ens(), 32'h00);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_flush", idex_flush, 1);
        chk("rst_bubble", memwb_bubble, 1);
        chk("rst_timeout", mem_timeout, 0);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_state", 32'(dut.state_q), 32'(RUN));
        chk("post_rst_stall", stall_cycles, 0);
        chk("post_rst_flush", flush_count, 0);
        chk("idle_enables", ens(), 32'h1F);
        chk("idle_flushes", {ifid_flush, idex_flush, memwb_bubble}, 0);
        tick();

        // Load-use on rs1.
        ex_mem_read = 1'b1; ex_wbs = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; id_uses_rs1 = 1'b1;
        settle();
        chk("lu_enables", ens(), 32'h07);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_ifid_flush", ifid_flush, 0);
        tick();
        clear_inputs();
        settle();
        chk("lu_stall_cnt", stall_cycles, 1);

        // Same registers but rs1 not read: no hazard.
        ex_mem_read = 1'b1; ex_wbs = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; id_uses_rs1 = 1'b0;
        settle();
        chk("nolu_enables", ens(), 32'h1F);
        chk("nolu_idex_flush", idex_flush, 0);
        tick();
        // Load-use on rs2.
        id_rs2 = 4'd3; id_uses_rs2 = 1'b1;
        settle();
        chk("lu_rs2_pc_en", pc_en, 0);
        tick();
        // Load without write-back: no hazard.
        ex_wbs = 1'b0;
        settle();
        chk("lu_nowbs_pc_en", pc_en, 1);
        tick();
        clear_inputs();
        settle();
        chk("lu_stall_cnt2", stall_cycles, 2);

        // Branch together with load-use resolves as a branch.
        ex_mem_read = 1'b1; ex_wbs = 1'b1; ex_rd = 4'd5; id_rs1 = 4'd5; id_uses_rs1 = 1'b1;
        branch_taken = 1'b1;
        settle();
        chk("br_enables", ens(), 32'h1F);
        chk("br_flushes", {ifid_flush, idex_flush, memwb_bubble}, 3'b110);
        tick();
        clear_inputs();
        settle();
        chk("br_flush_cnt", flush_count, 1);
        chk("br_stall_cnt", stall_cycles, 2);

        // Memory wait of 3 cycles with a branch held across it.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_enables", ens(), 32'h01);
            chk("mw_bubble", memwb_bubble, 1);
            chk("mw_flushes", {ifid_flush, idex_flush}, 0);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        chk("mw_rel_enables", ens(), 32'h1F);
        chk("mw_rel_bubble", memwb_bubble, 0);
        chk("mw_rel_flushes", {ifid_flush, idex_flush}, 2'b11);
        tick();
        clear_inputs();
        settle();
        chk("mw_rel_state", 32'(dut.state_q), 32'(RUN));
        chk("mw_stall_cnt", stall_cycles, 3);
        chk("mw_flush_cnt", flush_count, 1);

        // Zero-wait access never stalls.
        mem_req = 1'b1; mem_ready = 1'b1;
        settle();
        chk("zw_enables", ens(), 32'h1F);
        chk("zw_bubble", memwb_bubble, 0);
        tick();
        clear_inputs();
        settle();
        chk("zw_state", 32'(dut.state_q), 32'(RUN));
        chk("zw_stall_cnt", stall_cycles, 3);

        // Timeout: 4 frozen cycles, then ERROR with sticky flag.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("to_frozen_en", ens(), 32'h01);
            chk("to_frozen_flag", mem_timeout, 0);
            tick();
        end
        settle();
        chk("to_state", 32'(dut.state_q), 32'(ERROR));
        chk("to_flag", mem_timeout, 1);
        chk("to_err_enables", ens(), 32'h00);
        chk("to_err_bubble", memwb_bubble, 1);
        chk("to_stall_cnt", stall_cycles, 4);
        mem_ready = 1'b1; branch_taken = 1'b1;
        repeat (3) tick();
        settle();
        chk("to_sticky_state", 32'(dut.state_q), 32'(ERROR));
        chk("to_sticky_flag", mem_timeout, 1);
        chk("to_err_stall_cnt", stall_cycles, 7);
        chk("to_err_flush_cnt", flush_count, 0);
        clear_inputs();
        rst = 1'b1;
        settle();
        chk("to_rst_flag", mem_timeout, 0);
        chk("to_rst_enables", ens(), 32'h00);
        tick();
        rst = 1'b0;
        settle();
        chk("to_rec_state", 32'(dut.state_q), 32'(RUN));
        chk("to_rec_flag", mem_timeout, 0);
        chk("to_rec_enables", ens(), 32'h1F);
        chk("to_rec_stall_cnt", stall_cycles, 0);
        tick();

        // Reset in the second cycle of a memory wait.
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        settle();
        chk("rmw_state", 32'(dut.state_q), 32'(MEM_WAIT));
        rst = 1'b1;
        settle();
        chk("rmw_enables", ens(), 32'h00);
        chk("rmw_flushes", {ifid_flush, idex_flush, memwb_bubble}, 3'b111);
        tick();
        rst = 1'b0;
        clear_inputs();
        settle();
        chk("rmw_rec_state", 32'(dut.state_q), 32'(RUN));
        chk("rmw_stall_cnt", stall_cycles, 0);
        chk("rmw_flush_cnt", flush_count, 0);
        chk("rmw_flag", mem_timeout, 0);

        // 70000 load-use stall cycles saturate the stall counter.
        ex_mem_read = 1'b1; ex_wbs = 1'b1; ex_rd = 4'd7; id_rs2 = 4'd7; id_uses_rs2 = 1'b1;
        repeat (70000) tick();
        clear_inputs();
        settle();
        chk("sat_stall_cnt", stall_cycles, 32'h0000FFFF);
        tick();
        settle();
        chk("sat_idle_cnt", stall_cycles, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 16-bit five-stage CPU pipeline. It drives the enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits, and latches a sticky timeout if memory never answers. It also keeps two saturating performance counters.

## Interface
- `REG_ADDR_W`, default 4: register-address width.
- `MEM_WAIT_MAX`, default 15: consecutive frozen memory-wait cycles allowed before timeout. Legal range is 1..255.
- `clk` in 1: the single clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in `REG_ADDR_W`: source registers of the instruction in decode.
- `id_uses_rs1`, `id_uses_rs2` in 1: the matching source register is actually read.
- `ex_rd` in `REG_ADDR_W`: destination register of the instruction in EX.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_wbs` in 1: the instruction in EX writes back.
- `branch_taken` in 1: EX resolved a taken branch or jump.
- `mem_req` in 1: the MEM stage is accessing data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: register load enables.
- `ifid_flush`, `idex_flush` out 1: load a NOP or bubble instead of the incoming data.
- `memwb_bubble` out 1: forces `wbs` to 0 at the MEM/WB input.
- `mem_timeout` out 1: sticky error flag.
- `stall_cycles` out 16: saturating count of cycles with `pc_en`=0.
- `flush_count` out 16: saturating count of branch flushes.

## Operation
- The package enum `ctrl_state_t` has three states: RUN, MEM_WAIT and ERROR.
- **During `rst`:**
  - All `*_en` are 0.
  - `ifid_flush`, `idex_flush` and `memwb_bubble` are 1.
  - `mem_timeout`, the counters and `wait_cnt` are 0.
  - The state becomes RUN on the next edge.
- **Normal decode.** This applies in RUN, and in MEM_WAIT on the cycle `mem_ready`=1. The first matching rule wins.
  1. **Memory stall** (`mem_req` && !`mem_ready`):
     - `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0.
     - `memwb_en`=1 and `memwb_bubble`=1.
     - In RUN, the next state is MEM_WAIT and `wait_cnt`=1.
  2. **Branch** (`branch_taken`):
     - All enables are 1, and `ifid_flush`=1, `idex_flush`=1.
     - `flush_count` increments.
  3. **Load-use.** The hazard is `ex_mem_read` && `ex_wbs` && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
     - `pc_en`=0, `ifid_en`=0 and `idex_flush`=1.
     - `idex_en`, `exmem_en` and `memwb_en` are 1.
  4. **Otherwise:** all enables are 1, and all flushes and the bubble are 0.
- A simultaneous branch and load-use resolves as a branch, because the hazarding decode instruction is squashed.
- A branch presented during a memory stall is held, since EX is frozen. It is acted on in the release cycle.
- **MEM_WAIT:**
  - If `mem_ready`=1: apply normal decode and go to RUN.
  - Else, if `wait_cnt`==`MEM_WAIT_MAX`: go to ERROR.
  - Else: keep the memory-stall outputs and increment `wait_cnt`.
- **ERROR:**
  - All enables are 0, `memwb_bubble`=1 and `mem_timeout`=1.
  - The only exit is `rst`.
- A zero-wait access (`mem_req` && `mem_ready` in the same cycle) never stalls.
- `stall_cycles` increments in every non-reset cycle where `pc_en`=0, including ERROR, and saturates at 16'hFFFF.
- `flush_count` saturates at 16'hFFFF.
- `wait_cnt` is 8 bits wide. It cannot overflow, given the legal range of `MEM_WAIT_MAX`.

## Timing
- All control outputs are combinational from the state and the current inputs. They act on the same edge as the pipeline registers, so there is zero added latency.
- State, `wait_cnt`, `mem_timeout` and the counters are registered. Their updates are visible the cycle after the triggering condition.
- A memory wait of N cycles, where N ≤ `MEM_WAIT_MAX`, freezes the front pipeline for exactly N cycles. Release happens in the cycle `mem_ready` is seen.
- A timeout freezes for exactly `MEM_WAIT_MAX` cycles. ERROR and `mem_timeout` are active from the following cycle.
- A load-use stall is exactly one cycle: on the next cycle the load is in MEM and the hazard term is false.
- `rst` asserted in any state, including mid-MEM_WAIT, gives the reset outputs in that cycle and the RUN state after the edge.

## Structure
- The package `pipeline_ctrl_pkg` holds:
  - `ctrl_state_t`;
  - `CNT_W`=16 and `CNT_MAX`=16'hFFFF;
  - `WAIT_CNT_W`=8.
- One combinational sub-module, `load_use_detect`, holds the register-compare hazard term, parameterized by `REG_ADDR_W`.
- The FSM, the decode priority and the counters live in the top level.

## Test plan
- **Load-use.** Drive `ex_mem_read`=1, `ex_wbs`=1, `ex_rd`=3, `id_rs1`=3, `id_uses_rs1`=1 for one cycle.
  - Required: `pc_en`=0, `ifid_en`=0, `idex_flush`=1 that cycle.
  - Required: `stall_cycles`=1 afterward.
  - Repeat with `id_uses_rs1`=0: no stall.
- **Branch plus load-use in the same cycle.** Required: `pc_en`=1, `ifid_flush`=1, `idex_flush`=1 and `flush_count`=1.
- **Memory wait.** Hold `mem_req`=1 with `mem_ready`=0 for 3 cycles, then set `mem_ready`=1.
  - Required: the front enables are 0 and `memwb_bubble`=1 for 3 cycles.
  - Required: the 4th cycle is all-enabled, the state is RUN, and `stall_cycles`=3.
- **Timeout.** With `MEM_WAIT_MAX`=4, hold `mem_req`=1 with `mem_ready` never asserted.
  - Required: 4 frozen cycles, then `mem_timeout`=1 and ERROR.
  - Required: it stays set until `rst`, then recovers to RUN.
- **Reset mid-wait.** Assert `rst` in the 2nd MEM_WAIT cycle.
  - Required: reset outputs that cycle.
  - Required: RUN, zero counters and `mem_timeout`=0 afterward.
- **Zero-wait access and saturation.** Drive `mem_req` and `mem_ready` high together: no stall. Then force 70000 load-use stalls: `stall_cycles` holds 16'hFFFF.
